// File: rtl/tqvp_vga_probe_pkg.sv
// Shared constants for the VGA timing probe: register map, bit indices,
// counter widths, TinyVGA pin positions and the sampler state type.
package tqvp_vga_probe_pkg;

    localparam int unsigned XW = 12;
    localparam int unsigned YW = 11;

    localparam logic [XW-1:0] XMax = 12'hFFF;
    localparam logic [YW-1:0] YMax = 11'h7FF;

    localparam logic [5:0] AddrCtrl       = 6'h00;
    localparam logic [5:0] AddrSamplePos  = 6'h04;
    localparam logic [5:0] AddrSampleData = 6'h08;
    localparam logic [5:0] AddrLineLen    = 6'h0C;
    localparam logic [5:0] AddrHsWidth    = 6'h10;
    localparam logic [5:0] AddrFrameLines = 6'h14;
    localparam logic [5:0] AddrCurPos     = 6'h18;
    localparam logic [5:0] AddrStatus     = 6'h3C;

    localparam int unsigned CtrlHsPol       = 0;
    localparam int unsigned CtrlVsPol       = 1;
    localparam int unsigned CtrlIrqSampleEn = 2;
    localparam int unsigned CtrlIrqFrameEn  = 3;

    localparam int unsigned StatSamplePend = 0;
    localparam int unsigned StatFramePend  = 1;
    localparam int unsigned StatArmed      = 2;
    localparam int unsigned StatNoSignal   = 3;

    localparam int unsigned PinHsync = 7;
    localparam int unsigned PinVsync = 3;
    localparam int unsigned PinR1    = 0;
    localparam int unsigned PinR0    = 4;
    localparam int unsigned PinG1    = 1;
    localparam int unsigned PinG0    = 5;
    localparam int unsigned PinB1    = 2;
    localparam int unsigned PinB0    = 6;

    typedef enum logic [1:0] {
        SmpIdle,
        SmpArmed,
        SmpDone
    } smp_state_e;

    function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
        return (v == XMax) ? v : v + 12'd1;
    endfunction

    function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
        return (v == YMax) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/vga_sync_meter.sv
// Sync polarity, edge detection, pixel/line counters and timing measurements
// for an incoming VGA stream.
module vga_sync_meter
    import tqvp_vga_probe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          hsync_i,
    input  logic          vsync_i,
    input  logic          hs_pol_i,
    input  logic          vs_pol_i,
    output logic [XW-1:0] x_cnt_o,
    output logic [YW-1:0] y_cnt_o,
    output logic [XW-1:0] line_len_o,
    output logic [XW-1:0] hs_width_o,
    output logic [YW-1:0] frame_lines_o,
    output logic          vs_assert_o,
    output logic          no_signal_o
);

    localparam logic [XW-1:0] TimeoutX = XW'(TIMEOUT);

    logic          hs_act, vs_act;
    logic          hs_q, vs_q;
    logic          hs_assert, hs_deassert, vs_assert;
    logic [XW-1:0] x_cnt_q, x_cnt_d;
    logic [YW-1:0] y_cnt_q, y_cnt_d;
    logic [XW-1:0] line_len_q, line_len_d;
    logic [XW-1:0] hs_width_q, hs_width_d;
    logic [YW-1:0] frame_lines_q, frame_lines_d;
    logic          no_signal_q, no_signal_d;

    // A clear polarity bit selects an active-low pulse: *_act is high while the pulse is on.
    assign hs_act = ~(hsync_i ^ hs_pol_i);
    assign vs_act = ~(vsync_i ^ vs_pol_i);

    assign hs_assert   = hs_act & ~hs_q;
    assign hs_deassert = ~hs_act & hs_q;
    assign vs_assert   = vs_act & ~vs_q;

    always_comb begin
        x_cnt_d       = hs_assert ? '0 : sat_inc_x(x_cnt_q);
        y_cnt_d       = y_cnt_q;
        line_len_d    = hs_assert ? sat_inc_x(x_cnt_q) : line_len_q;
        hs_width_d    = hs_deassert ? sat_inc_x(x_cnt_q) : hs_width_q;
        frame_lines_d = vs_assert ? y_cnt_q : frame_lines_q;
        no_signal_d   = no_signal_q;

        if (vs_assert) begin
            y_cnt_d = '0;
        end else if (hs_assert) begin
            y_cnt_d = sat_inc_y(y_cnt_q);
        end

        // Flag in the same cycle x lands on the limit so a sample there is blocked.
        if (hs_assert) begin
            no_signal_d = 1'b0;
        end else if (x_cnt_d == TimeoutX) begin
            no_signal_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            line_len_q    <= '0;
            hs_width_q    <= '0;
            frame_lines_q <= '0;
            no_signal_q   <= 1'b0;
        end else begin
            hs_q          <= hs_act;
            vs_q          <= vs_act;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            line_len_q    <= line_len_d;
            hs_width_q    <= hs_width_d;
            frame_lines_q <= frame_lines_d;
            no_signal_q   <= no_signal_d;
        end
    end

    assign x_cnt_o       = x_cnt_q;
    assign y_cnt_o       = y_cnt_q;
    assign line_len_o    = line_len_q;
    assign hs_width_o    = hs_width_q;
    assign frame_lines_o = frame_lines_q;
    assign vs_assert_o   = vs_assert;
    assign no_signal_o   = no_signal_q;

endmodule

// File: rtl/tqvp_vga_probe.sv
// TinyQV peripheral that measures VGA timing and samples one pixel at a
// programmed position; holds the register file, sampler and interrupt.
module tqvp_vga_probe
    import tqvp_vga_probe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic [XW-1:0] x_cnt, line_len, hs_width;
    logic [YW-1:0] y_cnt, frame_lines;
    logic          vs_event, no_signal;

    logic [3:0]    ctrl_q, ctrl_d;
    logic [XW-1:0] sx_q, sx_d;
    logic [YW-1:0] sy_q, sy_d;
    logic [5:0]    sample_data_q, sample_data_d;
    logic          sample_pend_q, sample_pend_d;
    logic          frame_pend_q, frame_pend_d;
    smp_state_e    smp_q, smp_d;

    logic          wr_en, pos_wr, status_wr, match, capture, armed;
    logic [5:0]    pixel;
    logic          unused_bits;

    vga_sync_meter #(
        .TIMEOUT(TIMEOUT)
    ) u_meter (
        .clk_i        (clk),
        .rst_i        (rst),
        .hsync_i      (ui_in[PinHsync]),
        .vsync_i      (ui_in[PinVsync]),
        .hs_pol_i     (ctrl_q[CtrlHsPol]),
        .vs_pol_i     (ctrl_q[CtrlVsPol]),
        .x_cnt_o      (x_cnt),
        .y_cnt_o      (y_cnt),
        .line_len_o   (line_len),
        .hs_width_o   (hs_width),
        .frame_lines_o(frame_lines),
        .vs_assert_o  (vs_event),
        .no_signal_o  (no_signal)
    );

    assign wr_en     = (data_write_n != 2'b11);
    assign pos_wr    = (data_write_n == 2'b10) && (address == AddrSamplePos);
    assign status_wr = wr_en && (address == AddrStatus);
    assign match     = (x_cnt == sx_q) && (y_cnt == sy_q) && !no_signal;
    assign armed     = (smp_q == SmpArmed);
    assign pixel     = {ui_in[PinB1], ui_in[PinB0], ui_in[PinG1], ui_in[PinG0],
                        ui_in[PinR1], ui_in[PinR0]};

    // Sampler: a SAMPLE_POS write always re-arms, even over a same-cycle match.
    always_comb begin
        smp_d   = smp_q;
        capture = 1'b0;
        if (pos_wr) begin
            smp_d = SmpArmed;
        end else begin
            unique case (smp_q)
                SmpArmed: begin
                    if (match) begin
                        capture = 1'b1;
                        smp_d   = SmpDone;
                    end
                end
                SmpIdle, SmpDone: smp_d = smp_q;
                default:          smp_d = SmpIdle;
            endcase
        end
    end

    always_comb begin
        ctrl_d        = ctrl_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        sample_data_d = capture ? pixel : sample_data_q;
        if (wr_en && (address == AddrCtrl)) begin
            ctrl_d = data_in[3:0];
        end
        if (pos_wr) begin
            sx_d = data_in[XW-1:0];
            sy_d = data_in[16 +: YW];
        end
        sample_pend_d = capture  | (sample_pend_q & ~(status_wr & data_in[StatSamplePend]));
        frame_pend_d  = vs_event | (frame_pend_q  & ~(status_wr & data_in[StatFramePend]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_q         <= SmpIdle;
            ctrl_q        <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            sample_data_q <= '0;
            sample_pend_q <= 1'b0;
            frame_pend_q  <= 1'b0;
        end else begin
            smp_q         <= smp_d;
            ctrl_q        <= ctrl_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            sample_data_q <= sample_data_d;
            sample_pend_q <= sample_pend_d;
            frame_pend_q  <= frame_pend_d;
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            AddrCtrl:       data_out[3:0] = ctrl_q;
            AddrSamplePos:  data_out = {5'd0, sy_q, 4'd0, sx_q};
            AddrSampleData: data_out[5:0] = sample_data_q;
            AddrLineLen:    data_out[XW-1:0] = line_len;
            AddrHsWidth:    data_out[XW-1:0] = hs_width;
            AddrFrameLines: data_out[YW-1:0] = frame_lines;
            AddrCurPos:     data_out = {5'd0, y_cnt, 4'd0, x_cnt};
            AddrStatus:     data_out[3:0] = {no_signal, armed, frame_pend_q, sample_pend_q};
            default:        data_out = '0;
        endcase
    end

    assign user_interrupt = (sample_pend_q & ctrl_q[CtrlIrqSampleEn])
                          | (frame_pend_q & ctrl_q[CtrlIrqFrameEn]);
    assign uo_out         = '0;
    assign data_ready     = 1'b1;
    assign unused_bits    = ^{data_read_n, data_in[31:27], data_in[15:12]};

endmodule

// File: tb/tb_tqvp_vga_probe.sv
// Scoreboard bench for tqvp_vga_probe: a video generator drives ui_in, register
// reads push expected values, and a negedge monitor compares them.
module tb_tqvp_vga_probe;

    logic        clk;
    logic        rst;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int checks = 0;
    int errors = 0;

    string       nm_q[$];
    logic [31:0] mask_q[$];
    logic [31:0] exp_q[$];
    int          irq_q[$];

    int gen_h = 0;
    int gen_v = 0;
    bit gen_hold = 1'b0;
    bit gen_pol = 1'b0;

    tqvp_vga_probe #(
        .TIMEOUT(4095)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ui_in         (ui_in),
        .uo_out        (uo_out),
        .address       (address),
        .data_in       (data_in),
        .data_write_n  (data_write_n),
        .data_read_n   (data_read_n),
        .data_out      (data_out),
        .data_ready    (data_ready),
        .user_interrupt(user_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 100-clock lines, 10-clock hsync, 20-line frames, vsync edges mid-line.
    function automatic logic [7:0] video_bits(input int h, input int v, input bit pol);
        logic       hs;
        logic       vs;
        logic [5:0] pix;
        hs  = (h < 10);
        vs  = (v == 0 && h >= 50) || (v == 1) || (v == 2 && h < 50);
        pix = (v == 5 && h == 41) ? 6'h2D : 6'h12;
        if (!pol) begin
            hs = ~hs;
            vs = ~vs;
        end
        return {hs, pix[4], pix[2], pix[0], vs, pix[5], pix[3], pix[1]};
    endfunction

    always begin
        ui_in = video_bits(gen_h, gen_v, gen_pol);
        @(posedge clk);
        #1;
        if (!gen_hold) begin
            if (gen_h == 99) begin
                gen_h = 0;
                gen_v = (gen_v == 19) ? 0 : gen_v + 1;
            end else begin
                gen_h = gen_h + 1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        string       nm;
        logic [31:0] m;
        logic [31:0] e;
        int          ei;
        if (data_read_n != 2'b11) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: addr=%h data=%h", address, data_out);
            end else begin
                nm = nm_q.pop_front();
                m  = mask_q.pop_front();
                e  = exp_q.pop_front();
                ei = irq_q.pop_front();
                if (((data_out & m) != e) || (uo_out != 8'h00) ||
                    ((ei >= 0) && (user_interrupt != ei[0]))) begin
                    errors++;
                    $display("FAIL %s: got data=%h irq=%b uo=%h, expected data=%h irq=%0d uo=00",
                             nm, data_out & m, user_interrupt, uo_out, e, ei);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        address      = a;
        data_in      = d;
        data_write_n = wn;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic bus_read(input string name, input logic [5:0] a, input logic [31:0] mask,
                            input logic [31:0] exp, input int irq);
        address     = a;
        data_read_n = 2'b10;
        nm_q.push_back(name);
        mask_q.push_back(mask);
        exp_q.push_back(exp);
        irq_q.push_back(irq);
        tick();
        data_read_n = 2'b11;
    endtask

    task automatic wait_gen(input int v, input int h);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(gen_v == v && gen_h == h) && n < 5000);
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL wait_gen_timeout: got no line %0d pixel %0d, expected within 5000", v, h);
        end
    endtask

    task automatic read_all_zero(input string tag);
        logic [5:0] regs [8];
        regs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h3C};
        for (int i = 0; i < 8; i++) begin
            bus_read($sformatf("%s_%02h", tag, regs[i]), regs[i], 32'hFFFF_FFFF, 32'h0, 0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        tick();
        read_all_zero("reset");
        rst = 1'b0;

        // Active-low timing measurement
        repeat (4500) tick();
        bus_read("line_len", 6'h0C, 32'hFFFF_FFFF, 32'd100, -1);
        bus_read("hs_width", 6'h10, 32'hFFFF_FFFF, 32'd10, -1);
        bus_read("frame_lines", 6'h14, 32'hFFFF_FFFF, 32'd20, -1);
        bus_read("status_frame", 6'h3C, 32'hF, 32'h2, 0);

        // Sample capture with interrupt
        bus_write(6'h00, 32'h4, 2'b10);
        wait_gen(10, 0);
        bus_write(6'h04, 32'h0005_0028, 2'b10);
        bus_read("status_armed", 6'h3C, 32'h5, 32'h4, 0);
        bus_read("sample_pos", 6'h04, 32'hFFFF_FFFF, 32'h0005_0028, -1);
        repeat (2100) tick();
        bus_read("sample_data", 6'h08, 32'hFFFF_FFFF, 32'h2D, -1);
        bus_read("status_done", 6'h3C, 32'h5, 32'h1, 1);

        // Re-arm coinciding with a match does not capture
        bus_write(6'h3C, 32'h1, 2'b00);
        bus_read("status_w1c", 6'h3C, 32'h1, 32'h0, 0);
        wait_gen(5, 41);
        bus_write(6'h04, 32'h0005_0028, 2'b10);
        bus_read("rearm_no_capture", 6'h3C, 32'h5, 32'h4, 0);

        // W1C in the same cycle as a vs assert edge
        wait_gen(6, 0);
        wait_gen(0, 50);
        wait_gen(6, 0);
        wait_gen(0, 50);
        bus_write(6'h3C, 32'h3, 2'b00);
        bus_read("status_set_wins", 6'h3C, 32'h3, 32'h2, 0);
        bus_write(6'h00, 32'hFFFF_FFF8, 2'b01);
        bus_read("ctrl_low_bits", 6'h00, 32'hFFFF_FFFF, 32'h8, 1);

        // Loss of signal
        bus_write(6'h3C, 32'h3, 2'b10);
        wait_gen(7, 55);
        gen_hold = 1'b1;
        bus_write(6'h04, 32'h0007_0FFF, 2'b10);
        repeat (5000) tick();
        bus_read("cur_pos_sat", 6'h18, 32'h07FF_0FFF, 32'h0007_0FFF, -1);
        bus_read("status_nosig", 6'h3C, 32'hF, 32'hC, 0);
        bus_read("no_capture_nosig", 6'h08, 32'hFFFF_FFFF, 32'h2D, -1);
        gen_hold = 1'b0;
        wait_gen(8, 5);
        bus_read("line_len_sat", 6'h0C, 32'hFFFF_FFFF, 32'hFFF, -1);
        bus_read("nosig_clear", 6'h3C, 32'h8, 32'h0, -1);

        // Active-high source with inverted polarity bits
        gen_pol = 1'b1;
        bus_write(6'h00, 32'h3, 2'b10);
        repeat (4500) tick();
        bus_read("line_len_ah", 6'h0C, 32'hFFFF_FFFF, 32'd100, -1);
        bus_read("hs_width_ah", 6'h10, 32'hFFFF_FFFF, 32'd10, -1);
        bus_read("frame_lines_ah", 6'h14, 32'hFFFF_FFFF, 32'd20, -1);
        bus_write(6'h0C, 32'h0, 2'b10);
        bus_read("ro_ignored", 6'h0C, 32'hFFFF_FFFF, 32'd100, -1);
        bus_write(6'h3C, 32'h3, 2'b10);
        wait_gen(10, 0);
        bus_write(6'h04, 32'h0005_0028, 2'b10);
        repeat (2100) tick();
        bus_read("status_done_ah", 6'h3C, 32'h5, 32'h1, 0);
        bus_read("sample_data_ah", 6'h08, 32'hFFFF_FFFF, 32'h2D, -1);
        bus_write(6'h04, 32'h0003_0007, 2'b00);
        bus_read("pos_8bit_ignored", 6'h04, 32'hFFFF_FFFF, 32'h0005_0028, -1);
        bus_read("pos_8bit_no_arm", 6'h3C, 32'h4, 32'h0, -1);

        // Reset while armed mid-line
        wait_gen(3, 20);
        bus_write(6'h00, 32'hF, 2'b10);
        bus_write(6'h04, 32'h0005_0028, 2'b10);
        bus_read("armed_before_rst", 6'h3C, 32'h4, 32'h4, -1);
        rst = 1'b1;
        read_all_zero("midrst");
        rst = 1'b0;
        repeat (2100) tick();
        bus_read("post_rst_data", 6'h08, 32'hFFFF_FFFF, 32'h0, 0);
        bus_read("post_rst_status", 6'h3C, 32'h5, 32'h0, 0);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: got %0d unchecked, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
